// File: rtl/life_gen_ctrl_if.sv
// ---------------------------------------------------------------------------
// life_gen_ctrl_if
//   Control/status bundle between the Life generation controller and the
//   block driving it (host sequencer or testbench).
//
//   Parameters:
//     IDX_W  width of cell_idx
//     GEN_W  width of gen_count
//
//   Signals (direction seen from the controller, i.e. the slave modport):
//     in  load_req   level, request pattern load
//     in  run        level, free-run mode
//     in  step       1-cycle pulse, single generation when run=0
//     in  pause      level, hold in PAUSE
//     in  pace_tick  1-cycle pacing pulse
//     in  lose_sig   board-extinct flag from the array
//     in  mem_ready  array ready (only with LIFE_GEN_STALL_EN defined)
//     out state      current state code
//     out load_en    array takes external pattern bit
//     out read_en    array computes next-gen cell
//     out write_en   array writes cell at cell_idx
//     out commit     array swaps next-gen buffer into current
//     out clear      array writes 0 at cell_idx
//     out cell_idx   current cell address
//     out gen_count  committed generations
//     out busy       high in LOAD, STEP, COMMIT, CLEAR
//     out win        sticky win
//     out lose       sticky loss
//
//   Optional macro: LIFE_GEN_STALL_EN adds mem_ready.
// ---------------------------------------------------------------------------
interface life_gen_ctrl_if #(
    parameter int unsigned IDX_W = 6,
    parameter int unsigned GEN_W = 9
);
    logic             load_req;
    logic             run;
    logic             step;
    logic             pause;
    logic             pace_tick;
    logic             lose_sig;
`ifdef LIFE_GEN_STALL_EN
    logic             mem_ready;
`endif
    logic [2:0]       state;
    logic             load_en;
    logic             read_en;
    logic             write_en;
    logic             commit;
    logic             clear;
    logic [IDX_W-1:0] cell_idx;
    logic [GEN_W-1:0] gen_count;
    logic             busy;
    logic             win;
    logic             lose;

    modport master (
`ifdef LIFE_GEN_STALL_EN
        output mem_ready,
`endif
        output load_req, run, step, pause, pace_tick, lose_sig,
        input  state, load_en, read_en, write_en, commit, clear,
        input  cell_idx, gen_count, busy, win, lose
    );

    modport slave (
`ifdef LIFE_GEN_STALL_EN
        input  mem_ready,
`endif
        input  load_req, run, step, pause, pace_tick, lose_sig,
        output state, load_en, read_en, write_en, commit, clear,
        output cell_idx, gen_count, busy, win, lose
    );
endinterface

// File: rtl/life_gen_ctrl.sv
// ---------------------------------------------------------------------------
// life_gen_ctrl
//   Single-clock sequencer for the Life board datapath. Sweeps a
//   CELL_CNT-cell array for pattern load, generation step and board clear,
//   pulses commit after each load/step pass, counts committed generations
//   and latches win (WIN_GEN generations) or loss (extinction flag).
//   Free-run mode is paced by a coalescing pending-tick flag; single-step
//   and pause modes are also supported.
//
//   Ports:
//     clka   in   sole clock, rising edge
//     reset  in   synchronous, active-high; forces CLEAR from any state
//     bus    slave modport of life_gen_ctrl_if (control inputs, Moore
//            status/enable outputs, cell_idx, gen_count)
//
//   Parameters: CELL_CNT (>=2), IDX_W (2**IDX_W >= CELL_CNT),
//               WIN_GEN (>=1), GEN_W (2**GEN_W > WIN_GEN)
//
//   Optional macro: LIFE_GEN_STALL_EN -- sweeps in LOAD/STEP/CLEAR advance
//   only when bus.mem_ready=1; without it the sweep never stalls.
// ---------------------------------------------------------------------------
module life_gen_ctrl #(
    parameter int unsigned CELL_CNT = 64,
    parameter int unsigned IDX_W    = 6,
    parameter int unsigned WIN_GEN  = 10,
    parameter int unsigned GEN_W    = 9
) (
    input  logic           clka,
    input  logic           reset,
    life_gen_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'b000,
        S_WIN    = 3'b001,
        S_LOAD   = 3'b010,
        S_STEP   = 3'b011,
        S_COMMIT = 3'b100,
        S_PAUSE  = 3'b101,
        S_LOSE   = 3'b110,
        S_CLEAR  = 3'b111
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELL_CNT - 1);
    localparam logic [GEN_W-1:0] WIN_CNT  = GEN_W'(WIN_GEN);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic             pending_q, pending_d;
    logic             from_step_q, from_step_d;
    // {load_en, read_en, write_en, commit, clear, busy, win, lose}
    logic [7:0]       outs_q;

    logic             ready;
    logic             sweep_last;
    logic [GEN_W-1:0] gen_inc;

`ifdef LIFE_GEN_STALL_EN
    assign ready = bus.mem_ready;
`else
    assign ready = 1'b1;
`endif

    assign sweep_last = (idx_q == LAST_IDX);
    assign gen_inc    = gen_q + GEN_W'(1);

    // Enable/status decode of a state; registered against the next state so
    // the outputs line up with state_q without a combinational path.
    function automatic logic [7:0] decode(input state_t s);
        logic [7:0] o;
        o = '0;
        case (s)
            S_LOAD:   o = 8'b1010_0100;  // load_en, write_en, busy
            S_STEP:   o = 8'b0110_0100;  // read_en, write_en, busy
            S_COMMIT: o = 8'b0001_0100;  // commit, busy
            S_CLEAR:  o = 8'b0010_1100;  // write_en, clear, busy
            S_WIN:    o = 8'b0000_0010;  // win
            S_LOSE:   o = 8'b0000_0001;  // lose
            default:  o = '0;
        endcase
        return o;
    endfunction

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        gen_d       = gen_q;
        pending_d   = pending_q;
        from_step_d = from_step_q;

        // Pacing ticks coalesce into one pending flag; PAUSE discards it.
        case (state_q)
            S_PAUSE:                  pending_d = 1'b0;
            S_WIN, S_LOSE, S_CLEAR:   pending_d = pending_q;
            default:                  pending_d = pending_q | bus.pace_tick;
        endcase

        case (state_q)
            S_CLEAR: begin
                if (ready) begin
                    if (sweep_last) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            S_IDLE: begin
                if (bus.lose_sig) begin
                    state_d = S_LOSE;
                end else if (bus.load_req) begin
                    state_d = S_LOAD;
                end else if (bus.pause) begin
                    state_d = S_PAUSE;
                end else if (bus.run && pending_q) begin
                    state_d   = S_STEP;
                    // consume the pending tick, but keep one arriving now
                    pending_d = bus.pace_tick;
                end else if (!bus.run && bus.step) begin
                    state_d = S_STEP;
                end
            end

            S_LOAD, S_STEP: begin
                if (ready) begin
                    if (sweep_last) begin
                        state_d     = S_COMMIT;
                        idx_d       = '0;
                        from_step_d = (state_q == S_STEP);
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            S_COMMIT: begin
                idx_d = '0;
                if (from_step_q) begin
                    gen_d = gen_inc;
                end
                if (bus.lose_sig) begin
                    state_d = S_LOSE;
                end else if (from_step_q && (gen_inc == WIN_CNT)) begin
                    state_d = S_WIN;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_PAUSE: begin
                if (bus.lose_sig) begin
                    state_d = S_LOSE;
                end else if (!bus.pause) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                // WIN and LOSE are terminal until reset
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge clka) begin
        if (reset) begin
            state_q     <= S_CLEAR;
            idx_q       <= '0;
            gen_q       <= '0;
            pending_q   <= 1'b0;
            from_step_q <= 1'b0;
            outs_q      <= decode(S_CLEAR);
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            gen_q       <= gen_d;
            pending_q   <= pending_d;
            from_step_q <= from_step_d;
            outs_q      <= decode(state_d);
        end
    end

    assign bus.state     = state_q;
    assign bus.cell_idx  = idx_q;
    assign bus.gen_count = gen_q;
    assign bus.load_en   = outs_q[7];
    assign bus.read_en   = outs_q[6];
    assign bus.write_en  = outs_q[5];
    assign bus.commit    = outs_q[4];
    assign bus.clear     = outs_q[3];
    assign bus.busy      = outs_q[2];
    assign bus.win       = outs_q[1];
    assign bus.lose      = outs_q[0];

endmodule

// File: tb/tb_life_gen_ctrl.sv
// ---------------------------------------------------------------------------
// tb_life_gen_ctrl
//   Directed bench for life_gen_ctrl with CELL_CNT=4, WIN_GEN=4.
//   Inputs change 1 time unit after the rising edge; outputs are checked
//   at the same point, so each check sees the state after that edge.
// ---------------------------------------------------------------------------
module tb_life_gen_ctrl;

    localparam int unsigned CELL_CNT = 4;
    localparam int unsigned IDX_W    = 2;
    localparam int unsigned WIN_GEN  = 4;
    localparam int unsigned GEN_W    = 3;

    localparam logic [2:0] ST_IDLE   = 3'b000;
    localparam logic [2:0] ST_WIN    = 3'b001;
    localparam logic [2:0] ST_LOAD   = 3'b010;
    localparam logic [2:0] ST_STEP   = 3'b011;
    localparam logic [2:0] ST_COMMIT = 3'b100;
    localparam logic [2:0] ST_PAUSE  = 3'b101;
    localparam logic [2:0] ST_LOSE   = 3'b110;
    localparam logic [2:0] ST_CLEAR  = 3'b111;

    // {load_en, read_en, write_en, commit, clear, busy, win, lose}
    localparam logic [7:0] O_IDLE   = 8'b0000_0000;
    localparam logic [7:0] O_LOAD   = 8'b1010_0100;
    localparam logic [7:0] O_STEP   = 8'b0110_0100;
    localparam logic [7:0] O_COMMIT = 8'b0001_0100;
    localparam logic [7:0] O_CLEAR  = 8'b0010_1100;
    localparam logic [7:0] O_WIN    = 8'b0000_0010;
    localparam logic [7:0] O_LOSE   = 8'b0000_0001;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    life_gen_ctrl_if #(.IDX_W(IDX_W), .GEN_W(GEN_W)) bus ();

    life_gen_ctrl #(
        .CELL_CNT(CELL_CNT),
        .IDX_W   (IDX_W),
        .WIN_GEN (WIN_GEN),
        .GEN_W   (GEN_W)
    ) dut (
        .clka (clk),
        .reset(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] outs();
        return {bus.load_en, bus.read_en, bus.write_en, bus.commit,
                bus.clear, bus.busy, bus.win, bus.lose};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [2:0] st,
                          input logic [7:0] o);
        chk({tag, "/state"}, 32'(bus.state), 32'(st));
        chk({tag, "/outs"}, 32'(outs()), 32'(o));
    endtask

    // Single-step one generation from IDLE (run=0); optional lose on COMMIT.
    task automatic do_step(input logic lose_on_commit);
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        chk_st("ds_step", ST_STEP, O_STEP);
        repeat (CELL_CNT) tick();
        chk_st("ds_commit", ST_COMMIT, O_COMMIT);
        bus.lose_sig = lose_on_commit;
        tick();
    endtask

    initial begin
        #100000;
        $error("FAIL watchdog: observed timeout expected finish");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        bus.load_req  = 1'b0;
        bus.run       = 1'b0;
        bus.step      = 1'b0;
        bus.pause     = 1'b0;
        bus.pace_tick = 1'b0;
        bus.lose_sig  = 1'b0;
`ifdef LIFE_GEN_STALL_EN
        bus.mem_ready = 1'b1;
`endif

        // Reset held: CLEAR, idx/gen zero
        tick();
        tick();
        chk_st("rst", ST_CLEAR, O_CLEAR);
        chk("rst_idx", 32'(bus.cell_idx), 0);
        chk("rst_gen", 32'(bus.gen_count), 0);

        // CLEAR sweep: exactly CELL_CNT cycles after release
        rst = 1'b0;
        for (int i = 0; i < CELL_CNT; i++) begin
            chk_st("clr", ST_CLEAR, O_CLEAR);
            chk("clr_idx", 32'(bus.cell_idx), 32'(i));
            tick();
        end
        chk_st("clr_done", ST_IDLE, O_IDLE);
        chk("clr_done_gen", 32'(bus.gen_count), 0);

        // Pattern load: commit without generation increment
        bus.load_req = 1'b1;
        tick();
        bus.load_req = 1'b0;
        for (int i = 0; i < CELL_CNT; i++) begin
            chk_st("load", ST_LOAD, O_LOAD);
            chk("load_idx", 32'(bus.cell_idx), 32'(i));
            tick();
        end
        chk_st("load_commit", ST_COMMIT, O_COMMIT);
        chk("load_commit_idx", 32'(bus.cell_idx), 0);
        tick();
        chk_st("load_idle", ST_IDLE, O_IDLE);
        chk("load_gen", 32'(bus.gen_count), 0);

        // Single step; a second step pulse mid-pass is ignored
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        for (int i = 0; i < CELL_CNT; i++) begin
            chk_st("step", ST_STEP, O_STEP);
            chk("step_idx", 32'(bus.cell_idx), 32'(i));
            bus.step = (i == 1);
            tick();
        end
        bus.step = 1'b0;
        chk_st("step_commit_lat5", ST_COMMIT, O_COMMIT);
        tick();
        chk_st("step_idle", ST_IDLE, O_IDLE);
        chk("step_gen", 32'(bus.gen_count), 1);

        // Free run: one tick starts a pass, three ticks during it coalesce
        bus.run       = 1'b1;
        bus.pace_tick = 1'b1;
        tick();
        bus.pace_tick = 1'b0;
        chk_st("run_wait", ST_IDLE, O_IDLE);
        tick();
        chk_st("run_step1", ST_STEP, O_STEP);
        for (int i = 0; i < CELL_CNT; i++) begin
            bus.pace_tick = (i == 0 || i == 2);
            tick();
        end
        bus.pace_tick = 1'b1;
        chk_st("run_commit1", ST_COMMIT, O_COMMIT);
        tick();
        bus.pace_tick = 1'b0;
        chk("run_gen1", 32'(bus.gen_count), 2);
        tick();
        chk_st("run_step2", ST_STEP, O_STEP);
        repeat (CELL_CNT) tick();
        chk_st("run_commit2", ST_COMMIT, O_COMMIT);
        tick();
        chk("run_gen2", 32'(bus.gen_count), 3);
        tick();
        tick();
        chk_st("run_no_extra", ST_IDLE, O_IDLE);
        chk("run_gen_hold", 32'(bus.gen_count), 3);

        // Pause discards pacing ticks
        bus.run   = 1'b0;
        bus.pause = 1'b1;
        tick();
        chk_st("pause", ST_PAUSE, O_IDLE);
        bus.pace_tick = 1'b1;
        tick();
        bus.pace_tick = 1'b0;
        chk_st("pause_hold", ST_PAUSE, O_IDLE);
        bus.pause = 1'b0;
        bus.run   = 1'b1;
        tick();
        chk_st("unpause", ST_IDLE, O_IDLE);
        tick();
        chk_st("pause_tick_dropped", ST_IDLE, O_IDLE);
        bus.run = 1'b0;

        // Fourth generation wins; WIN is terminal
        do_step(1'b0);
        chk_st("win", ST_WIN, O_WIN);
        chk("win_gen", 32'(bus.gen_count), 4);
        bus.step     = 1'b1;
        bus.load_req = 1'b1;
        tick();
        bus.step     = 1'b0;
        bus.load_req = 1'b0;
        tick();
        chk_st("win_sticky", ST_WIN, O_WIN);
        chk("win_gen_hold", 32'(bus.gen_count), 4);

        // Reset out of WIN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_st("win_rst", ST_CLEAR, O_CLEAR);
        chk("win_rst_gen", 32'(bus.gen_count), 0);
        repeat (CELL_CNT) tick();
        chk_st("win_rst_idle", ST_IDLE, O_IDLE);

        // Reset mid-STEP
        do_step(1'b0);
        chk("mid_pre_gen", 32'(bus.gen_count), 1);
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        tick();
        tick();
        chk("mid_idx", 32'(bus.cell_idx), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_st("mid_rst", ST_CLEAR, O_CLEAR);
        chk("mid_rst_idx", 32'(bus.cell_idx), 0);
        chk("mid_rst_gen", 32'(bus.gen_count), 0);
        repeat (CELL_CNT) tick();
        chk_st("mid_rst_idle", ST_IDLE, O_IDLE);

`ifdef LIFE_GEN_STALL_EN
        // Stall: mem_ready low for two cycles at idx 1 stretches pass to 6
        begin
            int n;
            n = 0;
            bus.step = 1'b1;
            tick();
            bus.step = 1'b0;
            while (bus.state == ST_STEP && n < 20) begin
                if (n == 1) bus.mem_ready = 1'b0;
                if (n == 2) begin
                    chk("stall_idx", 32'(bus.cell_idx), 1);
                    chk("stall_outs", 32'(outs()), 32'(O_STEP));
                end
                if (n == 3) bus.mem_ready = 1'b1;
                tick();
                n++;
            end
            chk("stall_pass_len", 32'(n), 6);
            chk_st("stall_commit", ST_COMMIT, O_COMMIT);
            tick();
            chk("stall_gen", 32'(bus.gen_count), 1);
        end
        repeat (2) do_step(1'b0);
`else
        repeat (3) do_step(1'b0);
`endif

        // lose_sig on the winning COMMIT: LOSE takes priority
        chk("pre_lose_gen", 32'(bus.gen_count), 3);
        do_step(1'b1);
        chk_st("lose", ST_LOSE, O_LOSE);
        chk("lose_gen", 32'(bus.gen_count), 4);
        bus.lose_sig = 1'b0;
        tick();
        chk_st("lose_sticky", ST_LOSE, O_LOSE);

        // IDLE priority: lose_sig beats load_req
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (CELL_CNT) tick();
        chk_st("prio_idle", ST_IDLE, O_IDLE);
        bus.lose_sig = 1'b1;
        bus.load_req = 1'b1;
        tick();
        bus.lose_sig = 1'b0;
        bus.load_req = 1'b0;
        chk_st("prio_lose", ST_LOSE, O_LOSE);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
